// File: rtl/slip_add_pkg.sv
// Shared types and constants for the sliced add/sub/accumulate unit.
package slip_add_pkg;

   typedef enum logic [1:0] {
      ADD_OP = 2'b00,
      SUB_OP = 2'b01,
      ACC_OP = 2'b10,
      RSV_OP = 2'b11
   } add_mode_t;

   localparam int SLICE_W = 4;

endpackage

// File: rtl/slip_pipe_adder_if.sv
// Operand/result handshake bundle between a producer and the sliced adder.
interface slip_pipe_adder_if
   import slip_add_pkg::*;
#(
   parameter int WIDTH = 16
) ();

   logic             in_valid;
   logic             in_ready;
   add_mode_t        in_mode;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_ci;
   logic             acc_clr;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_q;
   logic             out_co;
   logic             out_ov;

   modport master (
      output in_valid, in_mode, in_a, in_b, in_ci, acc_clr, out_ready,
      input  in_ready, out_valid, out_q, out_co, out_ov
   );

   modport slave (
      input  in_valid, in_mode, in_a, in_b, in_ci, acc_clr, out_ready,
      output in_ready, out_valid, out_q, out_co, out_ov
   );

endinterface

// File: rtl/slip_add_slice4.sv
// Combinational 4-bit adder slice with carry-out and the carry into bit 3 for overflow.
module slip_add_slice4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       ci,
   output logic [3:0] q,
   output logic       co,
   output logic       c3
);

   logic [4:0] sum;
   logic [3:0] low;

   assign low = {1'b0, a[2:0]} + {1'b0, b[2:0]} + {3'b000, ci};
   assign sum = {1'b0, a} + {1'b0, b} + {4'b0000, ci};
   assign q   = sum[3:0];
   assign co  = sum[4];
   assign c3  = low[3];

endmodule

// File: rtl/slip_pipe_adder.sv
// WIDTH-bit add/sub/accumulate built from 4-bit slices, optionally one register per slice,
// with valid/ready flow control and a single-beat accumulator interlock.
module slip_pipe_adder
   import slip_add_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int SLICE = SLICE_W,
   parameter int PIPE  = 1
) (
   input logic                MasterClock,
   input logic                nReset,
   slip_pipe_adder_if.slave   bus
);

   localparam int NS = WIDTH / SLICE;

   logic             en;
   logic             in_fire;
   logic             is_acc;
   logic             is_sub;
   logic [WIDTH-1:0] opa;
   logic [WIDTH-1:0] opb;
   logic             ci_eff;

   logic [WIDTH-1:0] acc;
   logic             acc_busy;
   logic             retire_acc;

   logic             out_valid_r;
   logic [WIDTH-1:0] out_q_r;
   logic             out_co_r;
   logic             out_ov_r;

   logic [NS-1:0]    slice_c3;
   logic             v_last;
   logic             acc_last;
   logic             co_last;
   logic             ov_last;
   logic [WIDTH-1:0] q_last;

   assign en            = ~out_valid_r | bus.out_ready;
   assign bus.in_ready  = en & ~acc_busy & nReset;
   assign in_fire       = bus.in_valid & bus.in_ready;

   // Reserved mode falls through as ADD.
   assign is_acc = (bus.in_mode == ACC_OP);
   assign is_sub = (bus.in_mode == SUB_OP);
   assign opa    = is_acc ? acc : bus.in_a;
   assign opb    = is_sub ? ~bus.in_b : bus.in_b;
   assign ci_eff = is_sub ? ~bus.in_ci : bus.in_ci;

   // Stage k adds slice k; W = operand bits still pending, L = result bits already done.
   for (genvar k = 0; k < NS; k++) begin : g_st
      localparam int W = WIDTH - k*SLICE;
      localparam int L = k*SLICE;

      logic [W-1:0]       a_i;
      logic [W-1:0]       b_i;
      logic               c_i;
      logic               v_i;
      logic               acc_i;
      logic [SLICE-1:0]   sq;
      logic               co;
      logic [L+SLICE-1:0] lo_o;

      slip_add_slice4 u_slice (
         .a  (a_i[SLICE-1:0]),
         .b  (b_i[SLICE-1:0]),
         .ci (c_i),
         .q  (sq),
         .co (co),
         .c3 (slice_c3[k])
      );

      if (k == 0) begin : g_head
         assign a_i   = opa;
         assign b_i   = opb;
         assign c_i   = ci_eff;
         assign v_i   = in_fire;
         assign acc_i = is_acc;
         assign lo_o  = sq;
      end else if (PIPE != 0) begin : g_reg
         logic [W-1:0] r_a;
         logic [W-1:0] r_b;
         logic [L-1:0] r_lo;
         logic         r_c;
         logic         r_v;
         logic         r_acc;

         always_ff @(posedge MasterClock or negedge nReset) begin
            if (!nReset) begin
               r_a   <= '0;
               r_b   <= '0;
               r_lo  <= '0;
               r_c   <= 1'b0;
               r_v   <= 1'b0;
               r_acc <= 1'b0;
            end else if (en) begin
               r_a   <= g_st[k-1].a_i[W+SLICE-1:SLICE];
               r_b   <= g_st[k-1].b_i[W+SLICE-1:SLICE];
               r_lo  <= g_st[k-1].lo_o;
               r_c   <= g_st[k-1].co;
               r_v   <= g_st[k-1].v_i;
               r_acc <= g_st[k-1].acc_i;
            end
         end

         assign a_i   = r_a;
         assign b_i   = r_b;
         assign c_i   = r_c;
         assign v_i   = r_v;
         assign acc_i = r_acc;
         assign lo_o  = {sq, r_lo};
      end else begin : g_comb
         assign a_i   = g_st[k-1].a_i[W+SLICE-1:SLICE];
         assign b_i   = g_st[k-1].b_i[W+SLICE-1:SLICE];
         assign c_i   = g_st[k-1].co;
         assign v_i   = g_st[k-1].v_i;
         assign acc_i = g_st[k-1].acc_i;
         assign lo_o  = {sq, g_st[k-1].lo_o};
      end
   end

   assign v_last   = g_st[NS-1].v_i;
   assign acc_last = g_st[NS-1].acc_i;
   assign co_last  = g_st[NS-1].co;
   assign q_last   = g_st[NS-1].lo_o;
   assign ov_last  = slice_c3[NS-1] ^ co_last;

   // Only the MSB slice's bit-3 carry feeds overflow; lower taps are left unread.
   logic unused_c3;
   assign unused_c3 = ^slice_c3;

   assign retire_acc = en & v_last & acc_last;

   always_ff @(posedge MasterClock or negedge nReset) begin
      if (!nReset) begin
         out_valid_r <= 1'b0;
         out_q_r     <= '0;
         out_co_r    <= 1'b0;
         out_ov_r    <= 1'b0;
      end else if (en) begin
         out_valid_r <= v_last;
         if (v_last) begin
            out_q_r  <= q_last;
            out_co_r <= co_last;
            out_ov_r <= ov_last;
         end
      end
   end

   // Clear beats retirement; retirement beats a new ACC so unpipelined ACC never locks.
   always_ff @(posedge MasterClock or negedge nReset) begin
      if (!nReset) begin
         acc      <= '0;
         acc_busy <= 1'b0;
      end else begin
         if (bus.acc_clr) begin
            acc <= '0;
         end else if (retire_acc) begin
            acc <= q_last;
         end
         if (retire_acc) begin
            acc_busy <= 1'b0;
         end else if (in_fire && is_acc) begin
            acc_busy <= 1'b1;
         end
      end
   end

   assign bus.out_valid = out_valid_r;
   assign bus.out_q     = out_q_r;
   assign bus.out_co    = out_co_r;
   assign bus.out_ov    = out_ov_r;

endmodule
